// File: rtl/rr_mux4.sv
// Four-lane round-robin arbitrating multiplexer with a single registered output stage.
// The winning lane index travels with each beat on out_sel so a downstream demux can route it back.
module rr_mux4 #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel,
  input  logic           out_ready
);

  // Round-robin search: first valid lane starting at ptr, wrapping modulo 4.
  // Returns {found, lane}; lane is meaningless when found is 0.
  function automatic logic [2:0] find_grant(input logic [1:0] ptr, input logic [3:0] vld);
    logic       found;
    logic [1:0] lane;
    logic [1:0] idx;
    found = 1'b0;
    lane  = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && vld[idx]) begin
        found = 1'b1;
        lane  = idx;
      end
    end
    return {found, lane};
  endfunction

  logic [1:0]   ptr_q,       ptr_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic [1:0]   out_sel_q,   out_sel_d;

  logic         load;
  logic         grant_vld;
  logic [1:0]   grant_idx;
  logic [W-1:0] grant_data;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    load        = !out_valid_q || out_ready;
    {grant_vld, grant_idx} = find_grant(ptr_q, in_valid);
    grant_data  = in_data[int'(grant_idx)*W +: W];

    in_ready    = '0;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;

    // in_ready is forced low during reset so no source believes a beat was taken on the reset edge.
    if (rst_n && load && grant_vld) begin
      in_ready[grant_idx] = 1'b1;
    end

    if (load) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_data_d  = grant_data;
        out_sel_d   = grant_idx;
        ptr_d       = grant_idx + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      // NOTE: reset is synchronous; the whole output register is cleared, discarding any held beat.
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Scoreboard bench for rr_mux4: a queue-based arbitration model predicts each accepted beat,
// and an independent negedge monitor compares the DUT output stream and in_ready against it.
module tb_rr_mux4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  always #5 clk = ~clk;

  rr_mux4 #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  typedef logic [W-1:0] lane_q_t[$];

  lane_q_t src_q [4];   // beats each lane still has to send; head is on in_data
  beat_t   exp_q [$];   // beats the model says are held in / headed for the output
  int      m_ptr;
  bit      m_full;
  int      checks;
  int      errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane that wins when the priority pointer is ptr, or -1 if none is valid.
  function automatic int ref_grant(input int ptr, input logic [3:0] vld);
    for (int k = 0; k < 4; k++) begin
      if (vld[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]       = (src_q[i].size() > 0);
      in_data[i*W +: W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  // Model of one rising edge, evaluated on the pre-edge inputs.
  task automatic predict();
    int    g;
    bit    load;
    beat_t b;
    if (!rst_n) begin
      m_full = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      load = !m_full || out_ready;
      g    = ref_grant(m_ptr, in_valid);
      if (load && g >= 0) begin
        b.sel  = 2'(g);
        b.data = src_q[g].pop_front();
        exp_q.push_back(b);
        m_full = 1'b1;
        m_ptr  = (g + 1) % 4;
      end else if (load) begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    predict();
    #1;
    drive_inputs();
  endtask

  function automatic bit busy();
    for (int i = 0; i < 4; i++) if (src_q[i].size() > 0) return 1'b1;
    return exp_q.size() > 0;
  endfunction

  task automatic run_idle(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy() && n < 500) begin
      step();
      n++;
    end
    check({name, " drain timeout"}, 32'(busy()), 32'd0);
  endtask

  // Monitor: compares in_ready and the presented beat, pops on each downstream handshake.
  initial begin
    logic [3:0] exp_rdy;
    int         g;
    forever begin
      @(negedge clk);
      exp_rdy = 4'b0000;
      if (rst_n && (!m_full || out_ready)) begin
        g = ref_grant(m_ptr, in_valid);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_sel", 32'(out_sel), 32'(exp_q[0].sel));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected beat", 32'd1, 32'd0);
        else void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    m_full    = 1'b0;
    m_ptr     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;

    // Reset with every lane requesting.
    for (int i = 0; i < 4; i++) src_q[i].push_back(8'(8'h50 + i));
    drive_inputs();
    repeat (2) step();
    @(negedge clk);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_sel", 32'(out_sel), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("first lane after reset", 32'(out_sel), 32'd0);
    run_idle("reset");

    // Single lane back-to-back.
    src_q[2].push_back(8'h11);
    src_q[2].push_back(8'h22);
    src_q[2].push_back(8'h33);
    run_idle("single lane");

    // Full contention, constant lane data.
    for (int i = 0; i < 4; i++) repeat (12) src_q[i].push_back(8'(8'hA0 + i));
    run_idle("contention");

    // Backpressure from a fresh pointer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    src_q[1].push_back(8'h61);
    src_q[1].push_back(8'h62);
    src_q[3].push_back(8'h63);
    src_q[3].push_back(8'h64);
    drive_inputs();
    out_ready = 1'b0;
    step();
    repeat (5) begin
      step();
      check("stall out_sel", 32'(out_sel), 32'd1);
      check("stall out_data", 32'(out_data), 32'h61);
    end
    run_idle("backpressure");

    // Wrap and skip: lane 2 alone moves ptr to 3, then lanes 0 and 2 compete.
    src_q[2].push_back(8'h77);
    run_idle("wrap setup");
    src_q[0].push_back(8'h80);
    src_q[2].push_back(8'h82);
    run_idle("wrap");

    // Reset in the middle of contention.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(8'(16 * (i + 1) + k));
    drive_inputs();
    repeat (6) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    run_idle("midreset");

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if (src_q[i].size() < 4 && $urandom_range(0, 2) == 0)
          src_q[i].push_back(8'($urandom_range(0, 255)));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    run_idle("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
